// File: rtl/ps2_keyboard_io.sv
// ps2_keyboard_io: memory-mapped PS/2 keyboard receiver.
// Deserialises device-to-host PS/2 frames and queues the scan-code bytes in
// a FIFO. The CPU reads them through a STATUS/DATA register pair on the IO
// bus and pops the head by writing to DATA.
// Optional build macro: PS2_BREAK_FILTER_EN. When defined, a break prefix
// (8'hF0) and the byte that follows it are dropped, so only make codes are
// queued.
module ps2_keyboard_io #(
   parameter logic [15:0] BASE_ADDR      = 16'hFF10,
   parameter int          DEPTH          = 16,
   parameter int          TIMEOUT_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   input  logic [15:0] waddr,
   input  logic [15:0] wdata,
   input  logic        wenable,
   input  logic [15:0] raddr,
   output logic [15:0] rdata,
   output logic        irq
);

   localparam int          PW        = $clog2(DEPTH);
   localparam int          CW        = $clog2(DEPTH) + 1;
   localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } rx_state_t;

   // ---------------------------------------------------------------------
   // Reset: asserts asynchronously, releases on a clock edge.
   // ---------------------------------------------------------------------
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   // Two-flop reset release synchroniser.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   // ---------------------------------------------------------------------
   // PS/2 line synchronisers and falling-edge detection.
   // ---------------------------------------------------------------------
   logic [2:0] r_clk_sync;
   logic [1:0] r_dat_sync;
   logic       w_sample_en;
   logic       w_dat;

   // Resynchronise both lines; reset to the idle-high level so that reset
   // release cannot fake a falling edge.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge value of its neighbours, as real hardware does.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_clk_sync <= 3'b111;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_dat};
      end
   end

   assign w_sample_en = r_clk_sync[2] & ~r_clk_sync[1];
   assign w_dat       = r_dat_sync[1];

   // ---------------------------------------------------------------------
   // Receiver FSM.
   // ---------------------------------------------------------------------
   rx_state_t       r_state;
   rx_state_t       w_next_state;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift;
   logic            r_parity;
   logic [TW-1:0]   r_to_cnt;
   logic            w_timeout;
   logic            w_start;
   logic            w_shift_en;
   logic            w_par_en;
   logic            w_stop_en;
   logic            w_frame_ok;
   logic            w_frame_bad;

   // A sample enable restarts the timeout window, so it outranks an expiry.
   assign w_timeout = (r_state != S_IDLE) && !w_sample_en &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES));

   // Receiver state register.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state logic: advance on sample enables, abort on timeout.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      if (w_timeout) begin
         w_next_state = S_IDLE;
      end else if (w_sample_en) begin
         case (r_state)
            S_IDLE:   if (!w_dat) w_next_state = S_DATA;
            S_DATA:   if (r_bit_cnt == 3'd7) w_next_state = S_PARITY;
            S_PARITY: w_next_state = S_STOP;
            S_STOP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
         endcase
      end
   end

   // Output decode: per-state strobes for the datapath and frame checks.
   always_comb begin
      w_start     = w_sample_en && (r_state == S_IDLE) && !w_dat;
      w_shift_en  = w_sample_en && (r_state == S_DATA);
      w_par_en    = w_sample_en && (r_state == S_PARITY);
      w_stop_en   = w_sample_en && (r_state == S_STOP);
      w_frame_ok  = w_stop_en && w_dat && (^{r_shift, r_parity});
      w_frame_bad = w_stop_en && !w_frame_ok;
   end

   // Receive datapath: bit counter, LSB-first shifter and parity capture.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
         r_parity  <= 1'b0;
      end else begin
         if (w_start) r_bit_cnt <= 3'd0;
         if (w_shift_en) begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_par_en) r_parity <= w_dat;
      end
   end

   // Timeout counter: idles at zero, restarts on each sample enable.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n)                             r_to_cnt <= '0;
      else if (r_state == S_IDLE || w_sample_en) r_to_cnt <= '0;
      else if (r_to_cnt != TW'(TIMEOUT_CYCLES))  r_to_cnt <= r_to_cnt + TW'(1);
   end

   // ---------------------------------------------------------------------
   // Byte acceptance (optional break-code filter) and push staging.
   // ---------------------------------------------------------------------
   logic       w_accept;
   logic       r_push_pend;
   logic [7:0] r_push_byte;

`ifdef PS2_BREAK_FILTER_EN
   logic r_skip;

   // Skip flag: armed by a break prefix, consumed by the next valid byte.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_skip <= 1'b0;
      end else if (w_frame_ok) begin
         if (r_shift == 8'hF0) r_skip <= 1'b1;
         else if (r_skip)      r_skip <= 1'b0;
      end
   end

   assign w_accept = w_frame_ok && (r_shift != 8'hF0) && !r_skip;
`else
   assign w_accept = w_frame_ok;
`endif

   // Stage accepted bytes so the FIFO push lands one cycle after the stop bit.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_push_pend <= 1'b0;
         r_push_byte <= 8'h00;
      end else begin
         r_push_pend <= w_accept;
         if (w_accept) r_push_byte <= r_shift;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO.
   // ---------------------------------------------------------------------
   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_pop_req;
   logic          w_do_pop;
   logic          w_do_push;
   logic          w_ovf_set;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop_req = wenable && (waddr == DATA_ADDR);
   assign w_do_pop  = w_pop_req && !w_empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign w_do_push = r_push_pend && (!w_full || w_do_pop);
   assign w_ovf_set = r_push_pend && !w_do_push;

   // Storage write port.
   // NOTE: the storage array has no reset; count and pointers alone decide
   // which entries are valid, and DATA masks the head when empty.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= r_push_byte;
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Sticky status flags: a set outranks a write-1-to-clear.
   // ---------------------------------------------------------------------
   logic r_overflow;
   logic r_frame_err;
   logic w_stat_wr;

   assign w_stat_wr = wenable && (waddr == BASE_ADDR);

   // Overflow and frame-error flags.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_ovf_set)                 r_overflow  <= 1'b1;
         else if (w_stat_wr && wdata[2]) r_overflow  <= 1'b0;
         if (w_frame_bad)               r_frame_err <= 1'b1;
         else if (w_stat_wr && wdata[3]) r_frame_err <= 1'b0;
      end
   end

   // Remaining write-data bits carry no meaning for this peripheral.
   logic w_unused_wdata;
   assign w_unused_wdata = ^{wdata[15:4], wdata[1:0]};

   // ---------------------------------------------------------------------
   // Register read mux and registered outputs.
   // ---------------------------------------------------------------------
   logic [15:0] w_status;
   logic [15:0] w_rdata_next;

   assign w_status = {3'b000, 5'(r_count), 4'h0,
                      r_frame_err, r_overflow, w_full, !w_empty};

   // Address decode for the two readable registers.
   always_comb begin
      w_rdata_next = 16'h0000;
      if (raddr == BASE_ADDR)
         w_rdata_next = w_status;
      else if (raddr == DATA_ADDR && !w_empty)
         w_rdata_next = {8'h00, r_mem[r_rd_ptr]};
   end

   // Registered read data and interrupt.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         rdata <= 16'h0000;
         irq   <= 1'b0;
      end else begin
         rdata <= w_rdata_next;
         irq   <= !w_empty;
      end
   end

endmodule

// File: doc/ps2_keyboard_io.md
Name: ps2_keyboard_io

Overview:
- Memory-mapped PS/2 keyboard receiver. It is an upstream input peripheral on the CPU IO bus, alongside the VGA and hex peripherals.
- Deserialises PS/2 device-to-host frames and buffers received scan-code bytes in a FIFO.
- The CPU reads bytes through a STATUS/DATA register pair and pops them by writing to DATA.
- Runs on the same clock as the IO bus it serves.

Parameters:
- BASE_ADDR, 16'hFF10, word address of STATUS; DATA is at BASE_ADDR+1.
- DEPTH, 16, FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 50000, clock cycles without a falling ps2_clk edge before a partial frame is aborted.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clock.
- ps2_dat  in  1  raw PS/2 data, asynchronous to clock.
- waddr  in  16  IO write address.
- wdata  in  16  IO write data.
- wenable  in  1  IO write strobe; one write per cycle it is high.
- raddr  in  16  IO read address.
- rdata  out  16  IO read data, registered.
- irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO emptied; pointers and count = 0.
  - Receiver state = IDLE; overflow = 0; frame_err = 0.
  - rdata = 0; irq = 0.
- Input synchronisation:
  - ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
  - ps2_clk additionally needs a 3rd flop for edge detection.
  - A falling edge is synced value 0 with previous value 1. One sample enable per edge.
  - Data is sampled on that enable.
- Receiver FSM (all transitions occur only on a sample enable, except timeout):
  - IDLE: dat=0 -> DATA with bit_cnt=0. dat=1 -> stay in IDLE (spurious edge).
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: record the bit -> STOP.
  - STOP: if stop=1 and the 9 bits (data+parity) have odd parity -> push byte; otherwise set frame_err and discard. Either case -> IDLE.
  - Timeout:
    - The timeout counter clears on every sample enable and in IDLE.
    - When it reaches TIMEOUT_CYCLES in a non-IDLE state -> IDLE, partial byte discarded, no flag set.
- Push: occurs 1 cycle after the stop-bit sample enable.
- FIFO:
  - count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - Push when full: byte dropped, overflow set (sticky).
  - Pop when empty: ignored, no flag.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only.
- Registers:
  - STATUS (BASE_ADDR):
    - bit0 not_empty; bit1 full; bit2 overflow; bit3 frame_err.
    - bits[12:8] count; all other bits 0.
  - DATA (BASE_ADDR+1): [7:0] = FIFO head, [15:8] = 0. Reads are non-destructive. Reads 0 when empty.
- Read: rdata is updated every cycle from raddr, giving 1-cycle latency. Any address other than the two registers returns 16'h0000.
- Write to DATA (any wdata): pops one entry.
- Write to STATUS: write-1-to-clear; wdata[2] clears overflow, wdata[3] clears frame_err. If a set and a clear coincide in the same cycle, the set wins.
- Writes to other addresses are ignored.
- irq = not_empty, registered; it follows count with 1 cycle of lag.

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- Defined:
  - A received 8'hF0 is not pushed and arms a skip flag.
  - The next valid byte is discarded and clears the flag. Only make codes reach the FIFO.
  - A frame error or timeout does not clear the flag.
  - Reset clears the flag.
- Undefined: every valid byte, including 8'hF0, is pushed.

Test Plan:
- Reset then idle lines -> STATUS=16'h0000, DATA=16'h0000, irq=0.
- Send frame 0x1C (data 0,0,1,1,1,0,0,0; parity 0; stop 1) -> STATUS=16'h0101, DATA=16'h001C, irq=1. Write DATA -> STATUS=16'h0000, irq=0 within 2 cycles.
- Send 0x1C with parity bit 1 -> FIFO unchanged, STATUS bit3=1. Write STATUS wdata=16'h0008 -> bit3=0.
- Send 17 valid bytes 0x01..0x11 with DEPTH=16 -> STATUS=16'h1007 (count 16, full, overflow). DATA reads 0x01; 16 pops return 0x01..0x10 in order.
- Send start bit plus 3 data bits, then hold the lines high beyond TIMEOUT_CYCLES. Then send 0x2A -> only 0x2A is queued, no error flags.
- With PS2_BREAK_FILTER_EN defined, send 0x1C,0xF0,0x1C,0x32 -> FIFO holds 0x1C,0x32. Without the macro -> 0x1C,0xF0,0x1C,0x32.
